axis_32to8: RTL and testbench

- Width down-converter for the UDP datapath: accepts a 32-bit AXI-Stream with tkeep/tlast and emits an 8-bit AXI-Stream, one byte per cycle, in a single clock domain.
- Reverse direction of the 8→32 packer. Byte order matches the packer:
  - Valid bytes are right-justified in the word, i.e. tkeep is 0001, 0011, 0111 or 1111.
  - The first byte on the wire is the highest kept lane; lane 0 ([7:0]) is sent last.
- Also reports the frame length in bytes on every frame end.

---
 rtl/axis_width_pkg.sv | 33 +++
 rtl/axis_32to8.sv | 131 +++++++++++++
 tb/tb_axis_32to8.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_width_pkg.sv
// Shared AXI-Stream width-conversion helpers (used by the 8->32 packer and 32->8 unpacker).
package axis_width_pkg;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [WORD_BYTES-1:0] KEEP_1B = 4'b0001;
    localparam logic [WORD_BYTES-1:0] KEEP_2B = 4'b0011;
    localparam logic [WORD_BYTES-1:0] KEEP_3B = 4'b0111;
    localparam logic [WORD_BYTES-1:0] KEEP_4B = 4'b1111;

    // Byte count of a right-justified keep: highest set lane index + 1 (0 for 0000).
    function automatic logic [2:0] keep_to_nbytes(input logic [WORD_BYTES-1:0] keep);
        logic [2:0] n;
        n = 3'd0;
        if (keep[3]) begin
            n = 3'd4;
        end else if (keep[2]) begin
            n = 3'd3;
        end else if (keep[1]) begin
            n = 3'd2;
        end else if (keep[0]) begin
            n = 3'd1;
        end
        return n;
    endfunction

    // True for the right-justified patterns and the empty keep.
    function automatic logic keep_is_legal(input logic [WORD_BYTES-1:0] keep);
        return (keep == 4'b0000) || (keep == KEEP_1B) || (keep == KEEP_2B) ||
               (keep == KEEP_3B) || (keep == KEEP_4B);
    endfunction

endpackage

// File: rtl/axis_32to8.sv
// 32-bit to 8-bit AXI-Stream down-converter; highest kept lane goes out first.
// Also reports the byte length of every completed frame.
module axis_32to8
    import axis_width_pkg::*;
#(
    parameter int unsigned DEBUG     = 0,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          axis_tdata_in,
    input  logic [3:0]           axis_tkeep_in,
    input  logic                 axis_tvalid_in,
    input  logic                 axis_tlast_in,
    output logic                 axis_tready_out,
    output logic [7:0]           axis_tdata_out,
    output logic                 axis_tvalid_out,
    output logic                 axis_tlast_out,
    output logic                 axis_tfirst_out,
    input  logic                 axis_tready_in,
    output logic                 keep_err,
    output logic [LEN_WIDTH-1:0] frame_len_out,
    output logic                 frame_len_valid
);

    logic [31:0]          word_q;
    logic [2:0]           rem_q;
    logic                 last_q;
    logic                 first_q;
    logic                 keep_err_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 len_valid_q;

    logic                 load_c;
    logic                 byte_hs_c;
    logic                 keep_bad_c;
    logic [2:0]           nbytes_c;
    logic [LEN_WIDTH-1:0] cnt_inc_c;

    assign nbytes_c        = keep_to_nbytes(axis_tkeep_in);
    assign axis_tvalid_out = (rem_q != 3'd0);
    assign axis_tlast_out  = last_q && (rem_q == 3'd1);
    // Accept the next word in the same cycle the final held byte leaves, so bytes stay gap-free.
    assign axis_tready_out = reset_n &&
                             ((rem_q == 3'd0) ||
                              ((rem_q == 3'd1) && axis_tvalid_out && axis_tready_in));
    assign load_c          = axis_tvalid_in && axis_tready_out;
    assign byte_hs_c       = axis_tvalid_out && axis_tready_in;
    // An empty keep carrying tlast loses the frame end, so it is flagged like an illegal keep.
    assign keep_bad_c      = !keep_is_legal(axis_tkeep_in) ||
                             ((axis_tkeep_in == 4'b0000) && axis_tlast_in);
    assign cnt_inc_c       = (&cnt_q) ? cnt_q : cnt_q + LEN_WIDTH'(1);

    assign axis_tfirst_out = first_q;
    assign keep_err        = keep_err_q;
    assign frame_len_out   = len_q;
    assign frame_len_valid = len_valid_q;

    // Select lane rem_q-1 of the holding word.
    always_comb begin
        axis_tdata_out = 8'h00;
        case (rem_q)
            3'd1:    axis_tdata_out = word_q[7:0];
            3'd2:    axis_tdata_out = word_q[15:8];
            3'd3:    axis_tdata_out = word_q[23:16];
            3'd4:    axis_tdata_out = word_q[31:24];
            default: axis_tdata_out = 8'h00;
        endcase
    end

    // Holding word: a load overrides the byte-handshake decrement.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= 32'h0;
            rem_q  <= 3'd0;
            last_q <= 1'b0;
        end else if (load_c) begin
            word_q <= axis_tdata_in;
            rem_q  <= nbytes_c;
            last_q <= axis_tlast_in;
        end else if (byte_hs_c) begin
            rem_q  <= rem_q - 3'd1;
        end
    end

    // Frame byte counter and frame-length strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            len_q       <= '0;
            len_valid_q <= 1'b0;
        end else begin
            len_valid_q <= 1'b0;
            if (byte_hs_c) begin
                if (axis_tlast_out) begin
                    len_q       <= cnt_inc_c;
                    len_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end else begin
                    cnt_q       <= cnt_inc_c;
                end
            end
        end
    end

    // First-byte marker and sticky keep error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_q    <= 1'b1;
            keep_err_q <= 1'b0;
        end else begin
            if (byte_hs_c) begin
                first_q <= axis_tlast_out;
            end
            if (load_c && keep_bad_c) begin
                keep_err_q <= 1'b1;
            end
        end
    end

    // Optional probe register for an attached logic analyser.
    if (DEBUG != 0) begin : g_debug
        (* mark_debug = "true" *) logic [3:0] dbg_probe_unused;
        // Capture load handshake, keep error and length strobe.
        always_ff @(posedge clk) begin
            dbg_probe_unused <= {axis_tvalid_in, axis_tready_out, keep_err_q, len_valid_q};
        end
    end

endmodule

// File: tb/tb_axis_32to8.sv
// Randomized self-checking bench for axis_32to8 against a byte-queue reference model.
module tb_axis_32to8;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned LEN_W_S = 8;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic [31:0] axis_tdata_in  = 32'h0;
    logic [3:0]  axis_tkeep_in  = 4'h0;
    logic        axis_tvalid_in = 1'b0;
    logic        axis_tlast_in  = 1'b0;
    logic        axis_tready_in = 1'b1;

    logic             tready_out, tvalid_out, tlast_out, tfirst_out, keep_err, len_valid;
    logic [7:0]       tdata_out;
    logic [LEN_W-1:0] len_out;

    logic               s_tready_out, s_tvalid_out, s_tlast_out, s_tfirst_out, s_keep_err, s_len_valid;
    logic [7:0]         s_tdata_out;
    logic [LEN_W_S-1:0] s_len_out;

    axis_32to8 #(.DEBUG(0), .LEN_WIDTH(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .axis_tdata_in(axis_tdata_in), .axis_tkeep_in(axis_tkeep_in),
        .axis_tvalid_in(axis_tvalid_in), .axis_tlast_in(axis_tlast_in),
        .axis_tready_out(tready_out), .axis_tdata_out(tdata_out),
        .axis_tvalid_out(tvalid_out), .axis_tlast_out(tlast_out),
        .axis_tfirst_out(tfirst_out), .axis_tready_in(axis_tready_in),
        .keep_err(keep_err), .frame_len_out(len_out), .frame_len_valid(len_valid)
    );

    // Narrow-counter instance so length saturation is reachable in a short frame.
    axis_32to8 #(.DEBUG(0), .LEN_WIDTH(LEN_W_S)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .axis_tdata_in(axis_tdata_in), .axis_tkeep_in(axis_tkeep_in),
        .axis_tvalid_in(axis_tvalid_in), .axis_tlast_in(axis_tlast_in),
        .axis_tready_out(s_tready_out), .axis_tdata_out(s_tdata_out),
        .axis_tvalid_out(s_tvalid_out), .axis_tlast_out(s_tlast_out),
        .axis_tfirst_out(s_tfirst_out), .axis_tready_in(axis_tready_in),
        .keep_err(s_keep_err), .frame_len_out(s_len_out), .frame_len_valid(s_len_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of bytes still owed on the output, plus frame bookkeeping.
    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_byte_t;

    exp_byte_t   exp_q[$];
    logic        first_exp   = 1'b1;
    logic        err_exp     = 1'b0;
    logic        strobe_pend = 1'b0;
    int unsigned frame_cnt   = 0;
    int unsigned len_exp     = 0;

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
        int unsigned lim;
        lim = (32'd1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Model update and output comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("tready_in_reset", {31'd0, tready_out}, 32'd0);
            check("s_tready_in_reset", {31'd0, s_tready_out}, 32'd0);
            exp_q.delete();
            first_exp   = 1'b1;
            err_exp     = 1'b0;
            strobe_pend = 1'b0;
            frame_cnt   = 0;
        end else begin
            logic have;
            logic rdy_exp;
            have    = (exp_q.size() != 0);
            rdy_exp = (exp_q.size() == 0) || ((exp_q.size() == 1) && axis_tready_in);
            check("tvalid", {31'd0, tvalid_out}, {31'd0, have});
            check("s_tvalid", {31'd0, s_tvalid_out}, {31'd0, have});
            check("tready", {31'd0, tready_out}, {31'd0, rdy_exp});
            check("s_tready", {31'd0, s_tready_out}, {31'd0, rdy_exp});
            if (have) begin
                check("tdata", {24'd0, tdata_out}, {24'd0, exp_q[0].data});
                check("s_tdata", {24'd0, s_tdata_out}, {24'd0, exp_q[0].data});
                check("tlast", {31'd0, tlast_out}, {31'd0, exp_q[0].last});
                check("s_tlast", {31'd0, s_tlast_out}, {31'd0, exp_q[0].last});
            end
            check("tfirst", {31'd0, tfirst_out}, {31'd0, first_exp});
            check("s_tfirst", {31'd0, s_tfirst_out}, {31'd0, first_exp});
            check("keep_err", {31'd0, keep_err}, {31'd0, err_exp});
            check("s_keep_err", {31'd0, s_keep_err}, {31'd0, err_exp});
            check("len_valid", {31'd0, len_valid}, {31'd0, strobe_pend});
            check("s_len_valid", {31'd0, s_len_valid}, {31'd0, strobe_pend});
            if (strobe_pend) begin
                check("frame_len", 32'(len_out), sat(len_exp, LEN_W));
                check("s_frame_len", 32'(s_len_out), sat(len_exp, LEN_W_S));
            end

            strobe_pend = 1'b0;
            if (have && axis_tready_in) begin
                exp_byte_t b;
                b = exp_q.pop_front();
                frame_cnt++;
                first_exp = b.last;
                if (b.last) begin
                    strobe_pend = 1'b1;
                    len_exp     = frame_cnt;
                    frame_cnt   = 0;
                end
            end
            if (axis_tvalid_in && rdy_exp) begin
                int n;
                n = 0;
                for (int i = 0; i < 4; i++) if (axis_tkeep_in[i]) n = i + 1;
                for (int lane = n - 1; lane >= 0; lane--) begin
                    exp_byte_t nb;
                    nb.data = axis_tdata_in[lane*8 +: 8];
                    nb.last = axis_tlast_in && (lane == 0);
                    exp_q.push_back(nb);
                end
                if ((axis_tkeep_in != 4'((1 << n) - 1)) || ((n == 0) && axis_tlast_in))
                    err_exp = 1'b1;
            end
        end
    end

    // Downstream ready: scripted pattern first, otherwise random with bp_pct% stall.
    int   bp_pct = 0;
    logic rdy_pat[$];
    always @(posedge clk) begin
        #1;
        if (rdy_pat.size() != 0) axis_tready_in = rdy_pat.pop_front();
        else                     axis_tready_in = ($urandom_range(99) >= bp_pct);
    end

    // Present one word and hold it until accepted; returns stall cycles seen.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                             output int waits);
        logic done;
        axis_tdata_in  = d;
        axis_tkeep_in  = k;
        axis_tlast_in  = l;
        axis_tvalid_in = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (tready_out) done = 1'b1;
            else begin
                waits++;
                if (waits > 300) begin
                    check("send_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        axis_tvalid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || strobe_pend) && (n < 3000)) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic rand_frame(input int illegal_pct);
        int nw;
        int w;
        nw = $urandom_range(1, 6);
        for (int i = 0; i < nw; i++) begin
            logic [3:0] k;
            if (i < nw - 1) k = 4'hF;
            else            k = 4'((1 << $urandom_range(1, 4)) - 1);
            if (int'($urandom_range(99)) < illegal_pct) k = 4'($urandom_range(15));
            send_word($urandom, k, (i == nw - 1), w);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_tvalid", {31'd0, tvalid_out}, 32'd0);
        check("rst_tfirst", {31'd0, tfirst_out}, 32'd1);
        check("rst_keep_err", {31'd0, keep_err}, 32'd0);
        check("rst_len", 32'(len_out), 32'd0);
        check("rst_len_valid", {31'd0, len_valid}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back full words.
        send_word(32'h01020304, 4'hF, 1'b0, w);
        check("t1_first_wait", 32'(w), 32'd0);
        send_word(32'h05060708, 4'hF, 1'b1, w);
        check("t1_ready_low", 32'(w), 32'd3);
        drain();
        check("t1_len", 32'(len_out), 32'd8);
        check("t1_tfirst", {31'd0, tfirst_out}, 32'd1);

        // Single-byte frame, one cycle latency.
        send_word(32'h000000AA, 4'h1, 1'b1, w);
        @(negedge clk);
        check("t2_valid", {31'd0, tvalid_out}, 32'd1);
        check("t2_data", {24'd0, tdata_out}, 32'hAA);
        check("t2_last", {31'd0, tlast_out}, 32'd1);
        drain();
        check("t2_len", 32'(len_out), 32'd1);
        check("t2_tfirst", {31'd0, tfirst_out}, 32'd1);

        // Three-byte word under scripted backpressure.
        @(negedge clk); #1;
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        send_word(32'hAABBCCDD, 4'h7, 1'b1, w);
        drain();
        check("t3_len", 32'(len_out), 32'd3);

        // Illegal keep: three bytes emitted, sticky error.
        send_word(32'h11223344, 4'h5, 1'b1, w);
        drain();
        check("t4_keep_err", {31'd0, keep_err}, 32'd1);
        check("t4_len", 32'(len_out), 32'd3);
        send_word(32'h55667788, 4'hF, 1'b1, w);
        drain();
        check("t4_err_sticky", {31'd0, keep_err}, 32'd1);

        // Empty keep with tlast after a reset.
        pulse_reset();
        check("t4b_err_cleared", {31'd0, keep_err}, 32'd0);
        send_word(32'hDEADBEEF, 4'h0, 1'b1, w);
        @(negedge clk);
        check("t4b_no_output", {31'd0, tvalid_out}, 32'd0);
        check("t4b_keep_err", {31'd0, keep_err}, 32'd1);
        @(posedge clk); #1;

        // Reset mid-frame with two bytes outstanding.
        pulse_reset();
        send_word(32'hCAFEF00D, 4'hF, 1'b1, w);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_valid_after_rst", {31'd0, tvalid_out}, 32'd0);
        check("t5_no_strobe", {31'd0, len_valid}, 32'd0);
        @(posedge clk); #1;
        send_word(32'h01020304, 4'hF, 1'b0, w);
        send_word(32'h00000005, 4'h1, 1'b1, w);
        drain();
        check("t5_len", 32'(len_out), 32'd5);

        // 300-byte frame: narrow counter saturates.
        for (int i = 0; i < 75; i++) send_word($urandom, 4'hF, (i == 74), w);
        drain();
        check("t6_len16", 32'(len_out), 32'd300);
        check("t6_len8_sat", 32'(s_len_out), 32'd255);

        // Random legal frames with random backpressure.
        for (int f = 0; f < 40; f++) begin
            bp_pct = (f % 3) * 30;
            rand_frame(0);
        end
        drain();
        // Random frames including illegal keeps.
        for (int f = 0; f < 15; f++) begin
            bp_pct = 25;
            rand_frame(30);
        end
        bp_pct = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
